// File: rtl/risk_pkg.sv
// Shared RISK types: transaction op, tile-memory FSM states and
// size helpers used by the tile memory and the RISK sequencer.
package risk_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        ISSUE,
        RESP
    } state_e;

    function automatic int addr_w(input int logdepth, input int logcnt);
        return logdepth + logcnt;
    endfunction

    function automatic int nel(input int sz, input int sz_y);
        return sz * sz_y;
    endfunction

endpackage

// File: rtl/risk_bank.sv
// Single-port BITS x 2^LOGDEPTH RAM bank, one-cycle registered read.
// Ports: clk, en (access), we (write when en), addr, wdata, rdata (holds when not read).
module risk_bank #(
    parameter int BITS     = 18,
    parameter int LOGDEPTH = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [LOGDEPTH-1:0] addr,
    input  logic [BITS-1:0]     wdata,
    output logic [BITS-1:0]     rdata
);

    logic [BITS-1:0] mem [2**LOGDEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/risk_tile_mem.sv
// Strided tile memory: serves SZ_Y x SZ tiles over CNT banks, resolving conflicts over cycles.
// Ports: clk, reset, req_* (valid/ready request), rsp_* (valid/ready response), stall_cnt.
module risk_tile_mem
    import risk_pkg::*;
#(
    parameter  int SZ       = 4,
    parameter  int SZ_Y     = 4,
    parameter  int LOGCNT   = 5,
    parameter  int LOGDEPTH = 10,
    parameter  int BITS     = 18,
    localparam int ADDR_W   = addr_w(LOGDEPTH, LOGCNT),
    localparam int NEL      = nel(SZ, SZ_Y),
    localparam int TILE_W   = BITS * NEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_stride_x,
    input  logic [ADDR_W-1:0] req_stride_y,
    input  logic [TILE_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TILE_W-1:0] rsp_data,
    output logic [31:0]       stall_cnt
);

    localparam int CNT = 2**LOGCNT;

    state_e            state;
    op_e               op_q;
    logic [TILE_W-1:0] data_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] sx_q;
    logic [ADDR_W-1:0] sy_q;
    logic [ADDR_W-1:0] addr_q [NEL];
    logic [NEL-1:0]    pend_q;
    logic              first_q;
    logic [NEL-1:0]    cap_q  [CNT];
    logic [TILE_W-1:0] rsp_q;

    logic [ADDR_W-1:0]   addr_c [NEL];
    logic [NEL-1:0]      gnt    [CNT];
    logic [NEL-1:0]      gnt_all;
    logic [CNT-1:0]      b_en;
    logic [LOGDEPTH-1:0] b_row  [CNT];
    logic [BITS-1:0]     b_wd   [CNT];
    logic [BITS-1:0]     rd     [CNT];
    logic [TILE_W-1:0]   rsp_c;

    // Strides are two's-complement; truncated products give the wrap.
    always_comb begin
        for (int y = 0; y < SZ_Y; y++) begin
            for (int x = 0; x < SZ; x++) begin
                addr_c[y*SZ+x] = base_q
                               + ADDR_W'(x) * sx_q
                               + ADDR_W'(y) * sy_q;
            end
        end
    end

    // Per-bank priority encoder; the descending scan leaves the
    // lowest pending index as the winner.
    always_comb begin
        gnt_all = '0;
        b_en    = '0;
        for (int b = 0; b < CNT; b++) begin
            gnt[b]   = '0;
            b_row[b] = '0;
            b_wd[b]  = '0;
            for (int l = NEL - 1; l >= 0; l--) begin
                if (pend_q[l] &&
                    addr_q[l][LOGCNT-1:0] == LOGCNT'(b)) begin
                    gnt[b]    = '0;
                    gnt[b][l] = 1'b1;
                    b_row[b]  = addr_q[l][ADDR_W-1:LOGCNT];
                    b_wd[b]   = data_q[l*BITS +: BITS];
                end
            end
            // Reset blocks the access on the very edge it is sampled.
            b_en[b] = (state == ISSUE) && !reset && |gnt[b];
            gnt_all = gnt_all | gnt[b];
        end
    end

    // cap_q marks which element each bank read last cycle; the bank
    // output is OR-muxed into that slice. Driving the bypassed value
    // lets the final read show up in the first RESP cycle.
    always_comb begin
        logic [BITS-1:0] sl;
        logic            hit;
        rsp_c = rsp_q;
        for (int l = 0; l < NEL; l++) begin
            sl  = '0;
            hit = 1'b0;
            for (int b = 0; b < CNT; b++) begin
                if (cap_q[b][l]) begin
                    sl  = sl | rd[b];
                    hit = 1'b1;
                end
            end
            if (hit) begin
                rsp_c[l*BITS +: BITS] = sl;
            end
        end
    end

    assign rsp_data = rsp_c;

    for (genvar b = 0; b < CNT; b++) begin : g_bank
        risk_bank #(
            .BITS     (BITS),
            .LOGDEPTH (LOGDEPTH)
        ) u_bank (
            .clk   (clk),
            .en    (b_en[b]),
            .we    (b_en[b] && op_q == STORE),
            .addr  (b_row[b]),
            .wdata (b_wd[b]),
            .rdata (rd[b])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
            stall_cnt <= '0;
            pend_q    <= '0;
            first_q   <= 1'b0;
            for (int b = 0; b < CNT; b++) begin
                cap_q[b] <= '0;
            end
        end else begin
            rsp_q <= rsp_c;
            for (int b = 0; b < CNT; b++) begin
                cap_q[b] <= (state == ISSUE && op_q == LOAD)
                          ? gnt[b] : '0;
            end
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_e'(req_op);
                        data_q    <= req_data;
                        base_q    <= req_addr;
                        sx_q      <= req_stride_x;
                        sy_q      <= req_stride_y;
                        rsp_q     <= '0;
                        req_ready <= 1'b0;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    addr_q  <= addr_c;
                    pend_q  <= '1;
                    first_q <= 1'b1;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    pend_q  <= pend_q & ~gnt_all;
                    first_q <= 1'b0;
                    if (!first_q) begin
                        stall_cnt <= stall_cnt + 32'd1;
                    end
                    if ((pend_q & ~gnt_all) == '0) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risk_tile_mem.sv
// Self-checking bench for risk_tile_mem: random tiles against a flat
// memory model, plus directed conflict, wrap, alias, stall and reset cases.
module tb_risk_tile_mem;

    localparam int AW = 15;
    localparam int TW = 288;
    localparam int NE = 16;
    localparam int BT = 18;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_op = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [AW-1:0] req_stride_x = '0;
    logic [AW-1:0] req_stride_y = '0;
    logic [TW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_data;
    logic [31:0]   stall_cnt;

    always #5 clk = ~clk;

    risk_tile_mem dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_stride_x (req_stride_x),
        .req_stride_y (req_stride_y),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .stall_cnt    (stall_cnt)
    );

    int          checks = 0;
    int          failures = 0;
    logic [17:0] mem_m [0:32767];
    logic [31:0] stall_exp = '0;

    task automatic chk(input string tag, input logic [TW-1:0] got,
                       input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] ea(input logic [AW-1:0] a,
        input logic [AW-1:0] sx, input logic [AW-1:0] sy, input int l);
        return a + AW'(l % 4) * sx + AW'(l / 4) * sy;
    endfunction

    // Cycles needed = most elements landing in one bank.
    function automatic int n_conf(input logic [AW-1:0] a,
        input logic [AW-1:0] sx, input logic [AW-1:0] sy);
        int c [32];
        int mx;
        logic [AW-1:0] e;
        mx = 0;
        for (int b = 0; b < 32; b++) c[b] = 0;
        for (int l = 0; l < NE; l++) begin
            e = ea(a, sx, sy, l);
            c[e[4:0]]++;
            if (c[e[4:0]] > mx) mx = c[e[4:0]];
        end
        return mx;
    endfunction

    task automatic txn(input logic op, input logic [AW-1:0] a,
        input logic [AW-1:0] sx, input logic [AW-1:0] sy,
        input logic [TW-1:0] d, input int hold,
        output logic [TW-1:0] r, output int lat);
        int n;
        req_valid = 1'b1;
        req_op = op;
        req_addr = a;
        req_stride_x = sx;
        req_stride_y = sy;
        req_data = d;
        rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy", req_ready, 0);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("rsp_valid", rsp_valid, 1);
        lat = n + 1;
        r = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, r);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("idle_ready", req_ready, 1);
        chk("idle_valid", rsp_valid, 0);
    endtask

    task automatic run(input logic op, input logic [AW-1:0] a,
        input logic [AW-1:0] sx, input logic [AW-1:0] sy,
        input logic [TW-1:0] d, input int hold,
        output logic [TW-1:0] r);
        logic [TW-1:0] exp;
        int n;
        int lat;
        n = n_conf(a, sx, sy);
        exp = '0;
        for (int l = 0; l < NE; l++) begin
            if (op) mem_m[ea(a, sx, sy, l)] = d[l*BT +: BT];
            else exp[l*BT +: BT] = mem_m[ea(a, sx, sy, l)];
        end
        txn(op, a, sx, sy, d, hold, r, lat);
        stall_exp = stall_exp + 32'(n - 1);
        chk("rsp_data", r, exp);
        chk("latency", lat, n + 2);
        chk("stall_cnt", stall_cnt, stall_exp);
    endtask

    function automatic logic [TW-1:0] rnd_tile();
        logic [TW-1:0] t;
        for (int l = 0; l < NE; l++) t[l*BT +: BT] = BT'($urandom);
        return t;
    endfunction

    function automatic logic [AW-1:0] rnd_stride();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 40));
        return AW'($urandom);
    endfunction

    initial begin
        logic [TW-1:0] d;
        logic [TW-1:0] r;
        logic [AW-1:0] a;
        int lat;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_stall", stall_cnt, 0);
        reset = 1'b0;

        // Fill every word so all later loads have a known value.
        for (int k = 0; k < 2048; k++) begin
            run(1'b1, AW'(k * 16), 15'd1, 15'd4, rnd_tile(), 0, r);
        end

        for (int l = 0; l < NE; l++) d[l*BT +: BT] = BT'(l + 1);
        run(1'b1, 15'd0, 15'd1, 15'd4, d, 0, r);
        run(1'b0, 15'd0, 15'd1, 15'd4, '0, 0, r);
        chk("t1_elem15", r[15*BT +: BT], 16);

        run(1'b0, 15'd5, 15'd32, 15'd0, '0, 0, r);

        d = rnd_tile();
        run(1'b1, 15'h7fff, 15'd1, 15'd4, d, 0, r);
        run(1'b0, 15'h7fff, 15'd1, 15'd4, '0, 0, r);
        run(1'b0, 15'd0, 15'd1, 15'd4, '0, 0, r);
        chk("wrap_e1_at0", r[0 +: BT], d[BT +: BT]);

        d = rnd_tile();
        run(1'b1, 15'd0, 15'd1, 15'd0, d, 0, r);
        run(1'b0, 15'd0, 15'd1, 15'd4, '0, 0, r);
        chk("alias_e12", r[0 +: BT], d[12*BT +: BT]);
        chk("alias_e15", r[3*BT +: BT], d[15*BT +: BT]);

        run(1'b0, 15'd100, 15'd1, 15'd4, '0, 5, r);

        for (int i = 0; i < 60; i++) begin
            a = AW'($urandom);
            run(1'($urandom_range(0, 1)), a, rnd_stride(), rnd_stride(),
                rnd_tile(), $urandom_range(0, 2), r);
        end

        // Reset in the 4th ISSUE cycle of an all-conflict store.
        d = rnd_tile();
        req_valid = 1'b1;
        req_op = 1'b1;
        req_addr = 15'd7;
        req_stride_x = 15'd32;
        req_stride_y = 15'd0;
        req_data = d;
        chk("rst_t_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_stall", stall_cnt, 0);
        stall_exp = '0;
        for (int l = 0; l < 3; l++) mem_m[ea(15'd7, 15'd32, 15'd0, l)] = d[l*BT +: BT];
        @(posedge clk); #1;
        chk("rst_req_ignored", req_ready, 1);
        run(1'b0, 15'd7, 15'd32, 15'd0, '0, 0, r);
        chk("rst_e2_new", r[2*BT +: BT], d[2*BT +: BT]);

        d = rnd_tile();
        txn(1'b1, 15'd3, 15'd1, 15'd4, d, 0, r, lat);
        for (int l = 0; l < NE; l++) mem_m[ea(15'd3, 15'd1, 15'd4, l)] = d[l*BT +: BT];
        chk("store_rsp_zero", r, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
